// File: rtl/ok_btpipe_out_buffer_if.sv
// Fabric write port and okBTPipeOut host port of ok_btpipe_out_buffer.
// master = fabric/host side, slave = the buffer.
interface ok_btpipe_out_buffer_if #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_full;
  logic [DEPTH_LOG2:0] fill_level;
  logic              ep_read;
  logic              ep_blockstrobe;
  logic [15:0]       ep_datain;
  logic              ep_ready;
  logic              overflow;
  logic              underflow;
  logic              protocol_err;

  modport master (
    output wr_en, wr_data, ep_read, ep_blockstrobe,
    input  wr_full, fill_level, ep_datain, ep_ready, overflow, underflow, protocol_err
  );

  modport slave (
    input  wr_en, wr_data, ep_read, ep_blockstrobe,
    output wr_full, fill_level, ep_datain, ep_ready, overflow, underflow, protocol_err
  );
endinterface

// File: rtl/ok_btpipe_out_buffer.sv
// FIFO plus 16-bit serialiser that paces an okBTPipeOut endpoint in whole blocks.
// Define OK_BTPIPE_FLUSH_EN to add the flush input (short blocks padded with zeros).
module ok_btpipe_out_buffer #(
  parameter int DATA_W      = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS = 256
) (
  input logic ti_clk,
  input logic reset,
`ifdef OK_BTPIPE_FLUSH_EN
  input logic flush,
`endif
  ok_btpipe_out_buffer_if.slave bus
);
  localparam int LANES  = DATA_W / 16;
  localparam int DEPTH  = 2 ** DEPTH_LOG2;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W  = $clog2(BLOCK_WORDS + 1);
  localparam logic [DEPTH_LOG2:0] BLK_LVL   = (DEPTH_LOG2 + 1)'(BLOCK_WORDS / LANES);
  localparam logic [DEPTH_LOG2:0] FULL_LVL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [CNT_W-1:0]    BLK_CNT   = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0]    BLK_LAST  = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic {IDLE, BLOCK} state_t;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic [DATA_W-1:0]     ser_word;
  logic                  ser_valid;
  logic [LANE_W-1:0]     lane;
  logic [CNT_W-1:0]      rd_cnt;
  state_t                state, state_nxt;
  logic                  ep_ready_q, ep_ready_nxt;
  logic [15:0]           datain_q;
  logic                  ovf_q, unf_q, perr_q;
  logic                  pad_blk;
  logic                  push, pop, have_data, ready_cond;
  logic                  go_block, rd_ok, rd_bad, perr_set;
  logic [15:0]           rd_word;

  assign bus.wr_full = (level == FULL_LVL);
  assign push        = bus.wr_en && !bus.wr_full;
  assign have_data   = ser_valid || (level != '0);
  // The FIFO is only popped once the serialiser has sent its last lane.
  assign pop         = rd_ok && !ser_valid && (level != '0);

`ifdef OK_BTPIPE_FLUSH_EN
  assign ready_cond = (level >= BLK_LVL) || (flush && (level != '0));

  always_ff @(posedge ti_clk) begin
    if (reset)         pad_blk <= 1'b0;
    else if (go_block) pad_blk <= (level < BLK_LVL);
  end
`else
  assign ready_cond = (level >= BLK_LVL);
  assign pad_blk    = 1'b0;
`endif

  always_comb begin
    rd_word = ser_valid ? ser_word[16*lane +: 16] : mem[rd_ptr][15:0];
  end

  always_comb begin
    state_nxt    = state;
    ep_ready_nxt = 1'b0;
    go_block     = 1'b0;
    rd_ok        = 1'b0;
    rd_bad       = 1'b0;
    perr_set     = 1'b0;
    case (state)
      IDLE: begin
        rd_bad   = bus.ep_read;
        perr_set = bus.ep_read;
        if (bus.ep_blockstrobe && ep_ready_q) begin
          state_nxt = BLOCK;
          go_block  = 1'b1;
        end else begin
          ep_ready_nxt = ready_cond;
        end
      end
      BLOCK: begin
        rd_ok    = bus.ep_read && (rd_cnt < BLK_CNT);
        rd_bad   = bus.ep_read && (rd_cnt >= BLK_CNT);
        perr_set = rd_bad || bus.ep_blockstrobe;
        if (rd_ok && (rd_cnt == BLK_LAST)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ti_clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge ti_clk) begin
    if (reset) begin
      state      <= IDLE;
      ep_ready_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      rd_cnt     <= '0;
      datain_q   <= '0;
      ser_word   <= '0;
      ser_valid  <= 1'b0;
      lane       <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      ep_ready_q <= ep_ready_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
      if (go_block)   rd_cnt <= '0;
      else if (rd_ok) rd_cnt <= rd_cnt + 1'b1;
      if (bus.wr_en && bus.wr_full) ovf_q <= 1'b1;
      if (perr_set) perr_q <= 1'b1;
      if (rd_bad) begin
        datain_q <= '0;
      end else if (rd_ok) begin
        if (have_data) begin
          datain_q <= rd_word;
        end else begin
          datain_q <= '0;
          if (!pad_blk) unf_q <= 1'b1;
        end
      end
      // Lane 0 of a freshly popped word goes straight out; the rest wait here.
      if (rd_ok && ser_valid) begin
        if (lane == LAST_LANE) ser_valid <= 1'b0;
        else                   lane      <= lane + 1'b1;
      end else if (pop && (LANES > 1)) begin
        ser_word  <= mem[rd_ptr];
        ser_valid <= 1'b1;
        lane      <= LANE_W'(1);
      end
    end
  end

  assign bus.fill_level   = level;
  assign bus.ep_datain    = datain_q;
  assign bus.ep_ready     = ep_ready_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
  assign bus.protocol_err = perr_q;
endmodule

// File: tb/tb_ok_btpipe_out_buffer.sv
// Bench for ok_btpipe_out_buffer: a 16-bit and a 32-bit instance checked against
// queue models of the stored words and the host word stream.
module tb_ok_btpipe_out_buffer;
  logic clk = 1'b0;
  logic rst16, rst32, flush;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ok_btpipe_out_buffer_if #(.DATA_W(16), .DEPTH_LOG2(3)) b16 ();
  ok_btpipe_out_buffer_if #(.DATA_W(32), .DEPTH_LOG2(2)) b32 ();

  ok_btpipe_out_buffer #(.DATA_W(16), .DEPTH_LOG2(3), .BLOCK_WORDS(8)) dut16 (
    .ti_clk(clk),
    .reset(rst16),
`ifdef OK_BTPIPE_FLUSH_EN
    .flush(flush),
`endif
    .bus(b16)
  );

  ok_btpipe_out_buffer #(.DATA_W(32), .DEPTH_LOG2(2), .BLOCK_WORDS(4)) dut32 (
    .ti_clk(clk),
    .reset(rst32),
`ifdef OK_BTPIPE_FLUSH_EN
    .flush(flush),
`endif
    .bus(b32)
  );

  // Reference state: stored 16-bit words; stored 32-bit words plus lanes already sent of the front one
  logic [15:0] m16[$];
  logic [31:0] m32[$];
  int lane32 = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int fill32();
    return m32.size() - ((lane32 != 0) ? 1 : 0);
  endfunction

  task automatic m32_take(output logic [15:0] w);
    logic [31:0] f;
    f = m32[0];
    w = (lane32 == 0) ? f[15:0] : f[31:16];
    if (lane32 == 1) begin
      f = m32.pop_front();
      lane32 = 0;
    end else begin
      lane32 = 1;
    end
  endtask

  task automatic test_reset();
    flush = 1'b0;
    rst16 = 1'b1; rst32 = 1'b1;
    b16.wr_en = 0; b16.wr_data = '0; b16.ep_read = 0; b16.ep_blockstrobe = 0;
    b32.wr_en = 0; b32.wr_data = '0; b32.ep_read = 0; b32.ep_blockstrobe = 0;
    tick(); tick();
    rst16 = 1'b0; rst32 = 1'b0;
    checks++; if (b16.fill_level !== 4'd0) begin errors++; $display("FAIL reset16_fill got %0d want 0", b16.fill_level); end
    checks++; if (b16.ep_datain !== 16'h0) begin errors++; $display("FAIL reset16_datain got %h want 0000", b16.ep_datain); end
    checks++; if ({b16.wr_full, b16.ep_ready} !== 2'b00) begin errors++; $display("FAIL reset16_full_ready got %b want 00", {b16.wr_full, b16.ep_ready}); end
    checks++; if ({b16.overflow, b16.underflow, b16.protocol_err} !== 3'b000) begin errors++; $display("FAIL reset16_flags got %b want 000", {b16.overflow, b16.underflow, b16.protocol_err}); end
    checks++; if (b32.fill_level !== 3'd0) begin errors++; $display("FAIL reset32_fill got %0d want 0", b32.fill_level); end
    checks++; if (b32.ep_datain !== 16'h0) begin errors++; $display("FAIL reset32_datain got %h want 0000", b32.ep_datain); end
    checks++; if ({b32.wr_full, b32.ep_ready, b32.overflow, b32.underflow, b32.protocol_err} !== 5'b0) begin
      errors++; $display("FAIL reset32_status got %b want 00000", {b32.wr_full, b32.ep_ready, b32.overflow, b32.underflow, b32.protocol_err});
    end
  endtask

  task automatic test_block16();
    logic [15:0] exp;
    for (int i = 1; i <= 8; i++) begin
      b16.wr_en = 1; b16.wr_data = 16'(i); m16.push_back(16'(i)); tick();
    end
    b16.wr_en = 0;
    checks++; if (b16.ep_ready !== 1'b0) begin errors++; $display("FAIL blk16_ready_early got %b want 0", b16.ep_ready); end
    checks++; if (b16.wr_full !== 1'b1) begin errors++; $display("FAIL blk16_full got %b want 1", b16.wr_full); end
    tick();
    checks++; if (b16.ep_ready !== 1'b1) begin errors++; $display("FAIL blk16_ready got %b want 1", b16.ep_ready); end
    b16.ep_blockstrobe = 1; tick(); b16.ep_blockstrobe = 0;
    checks++; if (b16.ep_ready !== 1'b0) begin errors++; $display("FAIL blk16_ready_in_block got %b want 0", b16.ep_ready); end
    for (int i = 0; i < 8; i++) begin
      b16.ep_read = 1; exp = m16.pop_front(); tick();
      checks++; if (b16.ep_datain !== exp) begin errors++; $display("FAIL blk16_data[%0d] got %h want %h", i, b16.ep_datain, exp); end
    end
    b16.ep_read = 0;
    checks++; if (b16.fill_level !== 4'd0) begin errors++; $display("FAIL blk16_fill_end got %0d want 0", b16.fill_level); end
    tick();
    checks++; if (b16.ep_ready !== 1'b0) begin errors++; $display("FAIL blk16_ready_end got %b want 0", b16.ep_ready); end
  endtask

  task automatic test_idle_read16();
    for (int i = 0; i < 7; i++) begin
      b16.wr_en = 1; b16.wr_data = 16'($urandom); m16.push_back(b16.wr_data); tick();
    end
    b16.wr_en = 0;
    tick();
    checks++; if (b16.ep_ready !== 1'b0) begin errors++; $display("FAIL idle16_ready got %b want 0", b16.ep_ready); end
    checks++; if (b16.protocol_err !== 1'b0) begin errors++; $display("FAIL idle16_perr_before got %b want 0", b16.protocol_err); end
    b16.ep_blockstrobe = 1; tick(); b16.ep_blockstrobe = 0;
    b16.ep_read = 1; tick(); b16.ep_read = 0;
    checks++; if (b16.ep_datain !== 16'h0) begin errors++; $display("FAIL idle16_datain got %h want 0000", b16.ep_datain); end
    checks++; if (b16.protocol_err !== 1'b1) begin errors++; $display("FAIL idle16_perr got %b want 1", b16.protocol_err); end
    checks++; if (b16.fill_level !== 4'd7) begin errors++; $display("FAIL idle16_fill got %0d want 7", b16.fill_level); end
    checks++; if (b16.underflow !== 1'b0) begin errors++; $display("FAIL idle16_unf got %b want 0", b16.underflow); end
  endtask

  task automatic test_reset_mid16();
    logic [15:0] exp;
    b16.wr_en = 1; b16.wr_data = 16'($urandom); m16.push_back(b16.wr_data); tick();
    b16.wr_en = 0;
    tick();
    checks++; if (b16.ep_ready !== 1'b1) begin errors++; $display("FAIL rmid16_ready got %b want 1", b16.ep_ready); end
    b16.ep_blockstrobe = 1; tick(); b16.ep_blockstrobe = 0;
    for (int i = 0; i < 3; i++) begin
      b16.ep_read = 1; exp = m16.pop_front(); tick();
      checks++; if (b16.ep_datain !== exp) begin errors++; $display("FAIL rmid16_data[%0d] got %h want %h", i, b16.ep_datain, exp); end
    end
    rst16 = 1; tick(); rst16 = 0;
    m16.delete();
    checks++; if ({b16.ep_ready, b16.fill_level} !== 5'b0) begin errors++; $display("FAIL rmid16_ready_fill got %b want 00000", {b16.ep_ready, b16.fill_level}); end
    checks++; if ({b16.overflow, b16.underflow, b16.protocol_err} !== 3'b000) begin errors++; $display("FAIL rmid16_flags got %b want 000", {b16.overflow, b16.underflow, b16.protocol_err}); end
    checks++; if (b16.ep_datain !== 16'h0) begin errors++; $display("FAIL rmid16_datain_rst got %h want 0000", b16.ep_datain); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (b16.ep_datain !== 16'h0) begin errors++; $display("FAIL rmid16_datain_after[%0d] got %h want 0000", i, b16.ep_datain); end
    end
    b16.ep_read = 0;
    rst16 = 1; tick(); rst16 = 0;
  endtask

  task automatic test_random16();
    logic [15:0] exp;
    int fill_before, reads;
    logic rd, wr, exp_rdy;
    for (int r = 0; r < 4; r++) begin
      exp_rdy = 1'b0;
      while (!exp_rdy) begin
        wr = (m16.size() < 8) && ($urandom_range(3) != 0);
        b16.wr_en = wr; b16.wr_data = 16'($urandom);
        fill_before = m16.size();
        if (wr) m16.push_back(b16.wr_data);
        tick();
        exp_rdy = (fill_before >= 8);
        checks++; if (b16.ep_ready !== exp_rdy) begin errors++; $display("FAIL rnd16_ready got %b want %b", b16.ep_ready, exp_rdy); end
        checks++; if (b16.fill_level !== 4'(m16.size())) begin errors++; $display("FAIL rnd16_fill got %0d want %0d", b16.fill_level, m16.size()); end
      end
      b16.wr_en = 0;
      b16.ep_blockstrobe = 1; tick(); b16.ep_blockstrobe = 0;
      reads = 0;
      while (reads < 8) begin
        rd = ($urandom_range(2) != 0);
        wr = (m16.size() < 8) && ($urandom_range(1) == 0);
        b16.ep_read = rd; b16.wr_en = wr; b16.wr_data = 16'($urandom);
        if (rd) exp = m16.pop_front();
        if (wr) m16.push_back(b16.wr_data);
        tick();
        if (rd) begin
          reads++;
          checks++; if (b16.ep_datain !== exp) begin errors++; $display("FAIL rnd16_data got %h want %h", b16.ep_datain, exp); end
        end
        checks++; if (b16.fill_level !== 4'(m16.size())) begin errors++; $display("FAIL rnd16_blk_fill got %0d want %0d", b16.fill_level, m16.size()); end
        checks++; if (b16.ep_ready !== 1'b0) begin errors++; $display("FAIL rnd16_blk_ready got %b want 0", b16.ep_ready); end
      end
      b16.ep_read = 0; b16.wr_en = 0;
    end
    checks++; if ({b16.overflow, b16.underflow, b16.protocol_err} !== 3'b000) begin errors++; $display("FAIL rnd16_flags got %b want 000", {b16.overflow, b16.underflow, b16.protocol_err}); end
  endtask

  task automatic test_lanes32();
    logic [15:0] exp;
    b32.wr_en = 1; b32.wr_data = 32'hBBBB_AAAA; m32.push_back(b32.wr_data); tick();
    b32.wr_data = 32'hDDDD_CCCC; m32.push_back(b32.wr_data); tick();
    b32.wr_en = 0;
    checks++; if (b32.ep_ready !== 1'b0) begin errors++; $display("FAIL lanes32_ready_early got %b want 0", b32.ep_ready); end
    tick();
    checks++; if (b32.ep_ready !== 1'b1) begin errors++; $display("FAIL lanes32_ready got %b want 1", b32.ep_ready); end
    b32.ep_blockstrobe = 1; tick(); b32.ep_blockstrobe = 0;
    for (int i = 0; i < 4; i++) begin
      b32.ep_read = 1; m32_take(exp); tick();
      checks++; if (b32.ep_datain !== exp) begin errors++; $display("FAIL lanes32_data[%0d] got %h want %h", i, b32.ep_datain, exp); end
      checks++; if (b32.fill_level !== 3'(fill32())) begin errors++; $display("FAIL lanes32_fill[%0d] got %0d want %0d", i, b32.fill_level, fill32()); end
    end
    b32.ep_read = 0;
  endtask

  task automatic test_random32();
    logic [15:0] exp;
    int fill_before, reads;
    logic rd, wr, exp_rdy;
    for (int r = 0; r < 4; r++) begin
      exp_rdy = 1'b0;
      while (!exp_rdy) begin
        wr = (fill32() < 4) && ($urandom_range(3) != 0);
        b32.wr_en = wr; b32.wr_data = $urandom;
        fill_before = fill32();
        if (wr) m32.push_back(b32.wr_data);
        tick();
        exp_rdy = (fill_before >= 2);
        checks++; if (b32.ep_ready !== exp_rdy) begin errors++; $display("FAIL rnd32_ready got %b want %b", b32.ep_ready, exp_rdy); end
      end
      b32.wr_en = 0;
      b32.ep_blockstrobe = 1; tick(); b32.ep_blockstrobe = 0;
      reads = 0;
      while (reads < 4) begin
        rd = ($urandom_range(2) != 0);
        wr = (fill32() < 4) && ($urandom_range(1) == 0);
        b32.ep_read = rd; b32.wr_en = wr; b32.wr_data = $urandom;
        if (rd) m32_take(exp);
        if (wr) m32.push_back(b32.wr_data);
        tick();
        if (rd) begin
          reads++;
          checks++; if (b32.ep_datain !== exp) begin errors++; $display("FAIL rnd32_data got %h want %h", b32.ep_datain, exp); end
        end
        checks++; if (b32.fill_level !== 3'(fill32())) begin errors++; $display("FAIL rnd32_fill got %0d want %0d", b32.fill_level, fill32()); end
      end
      b32.ep_read = 0; b32.wr_en = 0;
    end
    checks++; if ({b32.overflow, b32.underflow, b32.protocol_err} !== 3'b000) begin errors++; $display("FAIL rnd32_flags got %b want 000", {b32.overflow, b32.underflow, b32.protocol_err}); end
  endtask

  task automatic test_overflow32();
    logic [15:0] exp;
    rst32 = 1; tick(); rst32 = 0;
    m32.delete(); lane32 = 0;
    for (int i = 1; i <= 5; i++) begin
      b32.wr_en = 1; b32.wr_data = $urandom;
      if (fill32() < 4) m32.push_back(b32.wr_data);
      tick();
      checks++; if (b32.wr_full !== (i >= 4)) begin errors++; $display("FAIL ovf32_full[%0d] got %b want %b", i, b32.wr_full, (i >= 4)); end
      checks++; if (b32.overflow !== (i == 5)) begin errors++; $display("FAIL ovf32_flag[%0d] got %b want %b", i, b32.overflow, (i == 5)); end
    end
    b32.wr_en = 0;
    checks++; if (b32.fill_level !== 3'd4) begin errors++; $display("FAIL ovf32_fill got %0d want 4", b32.fill_level); end
    checks++; if (b32.protocol_err !== 1'b0) begin errors++; $display("FAIL ovf32_perr_before got %b want 0", b32.protocol_err); end
    for (int blk = 0; blk < 2; blk++) begin
      tick();
      checks++; if (b32.ep_ready !== 1'b1) begin errors++; $display("FAIL ovf32_ready[%0d] got %b want 1", blk, b32.ep_ready); end
      b32.ep_blockstrobe = 1; tick(); b32.ep_blockstrobe = 0;
      for (int k = 0; k < 4; k++) begin
        b32.ep_read = 1;
        if (blk == 0 && k == 1) b32.ep_blockstrobe = 1;
        m32_take(exp); tick();
        b32.ep_blockstrobe = 0;
        checks++; if (b32.ep_datain !== exp) begin errors++; $display("FAIL ovf32_data[%0d][%0d] got %h want %h", blk, k, b32.ep_datain, exp); end
      end
      b32.ep_read = 0;
    end
    checks++; if (b32.protocol_err !== 1'b1) begin errors++; $display("FAIL ovf32_perr got %b want 1", b32.protocol_err); end
    checks++; if ({b32.fill_level, b32.underflow} !== 4'b0) begin errors++; $display("FAIL ovf32_end got %b want 0000", {b32.fill_level, b32.underflow}); end
  endtask

`ifdef OK_BTPIPE_FLUSH_EN
  task automatic test_flush16();
    logic [15:0] exp;
    rst16 = 1; tick(); rst16 = 0;
    m16.delete();
    for (int i = 0; i < 3; i++) begin
      b16.wr_en = 1; b16.wr_data = 16'($urandom_range(65535, 1)); m16.push_back(b16.wr_data); tick();
    end
    b16.wr_en = 0; flush = 1; tick();
    checks++; if (b16.ep_ready !== 1'b1) begin errors++; $display("FAIL flush16_ready got %b want 1", b16.ep_ready); end
    b16.ep_blockstrobe = 1; tick(); b16.ep_blockstrobe = 0; flush = 0;
    for (int i = 0; i < 8; i++) begin
      b16.ep_read = 1;
      exp = (m16.size() > 0) ? m16.pop_front() : 16'h0000;
      tick();
      checks++; if (b16.ep_datain !== exp) begin errors++; $display("FAIL flush16_data[%0d] got %h want %h", i, b16.ep_datain, exp); end
    end
    b16.ep_read = 0;
    checks++; if ({b16.underflow, b16.protocol_err} !== 2'b00) begin errors++; $display("FAIL flush16_flags got %b want 00", {b16.underflow, b16.protocol_err}); end
    checks++; if (b16.fill_level !== 4'd0) begin errors++; $display("FAIL flush16_fill got %0d want 0", b16.fill_level); end
  endtask
`else
  task automatic test_no_flush16();
    rst16 = 1; tick(); rst16 = 0;
    m16.delete();
    for (int i = 0; i < 3; i++) begin
      b16.wr_en = 1; b16.wr_data = 16'($urandom); m16.push_back(b16.wr_data); tick();
    end
    b16.wr_en = 0; tick(); tick();
    checks++; if (b16.ep_ready !== 1'b0) begin errors++; $display("FAIL noflush16_ready got %b want 0", b16.ep_ready); end
    checks++; if (b16.fill_level !== 4'd3) begin errors++; $display("FAIL noflush16_fill got %0d want 3", b16.fill_level); end
  endtask
`endif

  initial begin
    test_reset();
    test_block16();
    test_idle_read16();
    test_reset_mid16();
    test_random16();
    test_lanes32();
    test_random32();
    test_overflow32();
`ifdef OK_BTPIPE_FLUSH_EN
    test_flush16();
`else
    test_no_flush16();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
